// File: rtl/flag_sequencer.sv
`default_nettype none
// ==========================================================================
// flag_sequencer : frame-rate flag scheduler with optional top-down wipe
// Optional feature macro: FLAG_SEQ_WIPE_EN              Revision: 1.0
// ==========================================================================
module flag_sequencer #(
  parameter int NUM_FLAGS   = 16,
  parameter int SEL_W       = 5,
  parameter int HOLD_FRAMES = 300,
  parameter int WIPE_STEP   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             pause,
  output logic [SEL_W-1:0] flag_sel,
  output logic [SEL_W-1:0] prev_sel,
  output logic [9:0]       wipe_y,
  output logic             busy
);

`ifdef FLAG_SEQ_WIPE_EN
  localparam bit WIPE_EN = 1'b1;
`else
  localparam bit WIPE_EN = 1'b0;
`endif

  localparam logic [9:0]       ROWS      = 10'd480;
  localparam logic [10:0]      STEP      = 11'(WIPE_STEP);
  localparam logic [15:0]      HOLD_LAST = 16'(HOLD_FRAMES - 1);
  localparam logic [SEL_W-1:0] LAST_FLAG = SEL_W'(NUM_FLAGS - 1);

  typedef enum logic [0:0] {
    S_HOLD = 1'b0,
    S_WIPE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             vsync_q;
  logic [1:0]       next_sync_q, next_sync_d, prev_sync_q, prev_sync_d;
  logic [1:0]       next_s_q, next_s_d, prev_s_q, prev_s_d;
  logic             next_lvl_q, next_lvl_d, prev_lvl_q, prev_lvl_d;
  logic [15:0]      hold_cnt_q, hold_cnt_d;
  logic [SEL_W-1:0] flag_sel_q, flag_sel_d, prev_sel_q, prev_sel_d;
  logic [9:0]       wipe_y_q, wipe_y_d;
  logic [10:0]      wipe_sum;
  logic             tick, next_ev, prev_ev, adv_up, adv_dn;

  // Button conditioning: 2-flop sync on clk, then frame-rate sampling/debounce.
  always_comb begin
    tick        = vsync & ~vsync_q;
    next_sync_d = {next_sync_q[0], btn_next};
    prev_sync_d = {prev_sync_q[0], btn_prev};
    next_s_d    = next_s_q;
    prev_s_d    = prev_s_q;
    next_lvl_d  = next_lvl_q;
    prev_lvl_d  = prev_lvl_q;
    if (tick) begin
      next_s_d = {next_s_q[0], next_sync_q[1]};
      prev_s_d = {prev_s_q[0], prev_sync_q[1]};
      if (next_s_d[1] == next_s_d[0]) next_lvl_d = next_s_d[0];
      if (prev_s_d[1] == prev_s_d[0]) prev_lvl_d = prev_s_d[0];
    end
    next_ev = tick & next_lvl_d & ~next_lvl_q;
    prev_ev = tick & prev_lvl_d & ~prev_lvl_q;
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    flag_sel_d = flag_sel_q;
    prev_sel_d = prev_sel_q;
    wipe_y_d   = wipe_y_q;
    adv_up     = 1'b0;
    adv_dn     = 1'b0;
    wipe_sum   = {1'b0, wipe_y_q} + STEP;

    if (tick) begin
      case (state_q)
        S_HOLD: begin
          if (next_ev && !prev_ev) begin
            adv_up = 1'b1;
          end else if (prev_ev && !next_ev) begin
            adv_dn = 1'b1;
          end else if (!pause) begin
            if (hold_cnt_q == HOLD_LAST) adv_up = 1'b1;
            else                         hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
        S_WIPE: begin
          // Button events arriving mid-wipe are dropped on purpose.
          if (wipe_sum >= {1'b0, ROWS}) begin
            wipe_y_d   = ROWS;
            prev_sel_d = flag_sel_q;
            state_d    = S_HOLD;
          end else begin
            wipe_y_d = wipe_sum[9:0];
          end
        end
        default: state_d = S_HOLD;
      endcase
    end

    if (adv_up || adv_dn) begin
      if (adv_up) flag_sel_d = (flag_sel_q == LAST_FLAG) ? '0 : flag_sel_q + SEL_W'(1);
      else        flag_sel_d = (flag_sel_q == '0) ? LAST_FLAG : flag_sel_q - SEL_W'(1);
      hold_cnt_d = '0;
      if (WIPE_EN) begin
        prev_sel_d = flag_sel_q;
        wipe_y_d   = '0;
        state_d    = S_WIPE;
      end else begin
        prev_sel_d = flag_sel_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HOLD;
      vsync_q     <= 1'b0;
      next_sync_q <= '0;
      prev_sync_q <= '0;
      next_s_q    <= '0;
      prev_s_q    <= '0;
      next_lvl_q  <= 1'b0;
      prev_lvl_q  <= 1'b0;
      hold_cnt_q  <= '0;
      flag_sel_q  <= '0;
      prev_sel_q  <= '0;
      wipe_y_q    <= ROWS;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      next_sync_q <= next_sync_d;
      prev_sync_q <= prev_sync_d;
      next_s_q    <= next_s_d;
      prev_s_q    <= prev_s_d;
      next_lvl_q  <= next_lvl_d;
      prev_lvl_q  <= prev_lvl_d;
      hold_cnt_q  <= hold_cnt_d;
      flag_sel_q  <= flag_sel_d;
      prev_sel_q  <= prev_sel_d;
      wipe_y_q    <= wipe_y_d;
    end
  end

  assign flag_sel = flag_sel_q;
  assign prev_sel = prev_sel_q;
  assign wipe_y   = WIPE_EN ? wipe_y_q : ROWS;
  assign busy     = WIPE_EN & (state_q == S_WIPE);

endmodule
`default_nettype wire

// File: doc/flag_sequencer.md
# flag_sequencer

Frame-rate scheduler for the pride-flag display. It decides which flag generator drives the 6-bit RRGGBB colour bus. It auto-advances through `NUM_FLAGS` flags every `HOLD_FRAMES` frames and accepts debounced next/prev buttons. It also produces a top-down wipe line so that the downstream colour mux can blend the outgoing and incoming flags by row. It sits between the VGA sync generator and the flag mux.

## Interface
Parameters:
- `NUM_FLAGS`, 16: number of selectable flags, 2..32.
- `SEL_W`, 5: width of flag indices; must satisfy 2^SEL_W >= NUM_FLAGS.
- `HOLD_FRAMES`, 300: frames each flag is shown before auto-advance, 1..65535.
- `WIPE_STEP`, 16: rows the wipe line moves per frame, 1..480.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `vsync`  in  1  active-high vertical sync from the sync generator.
- `btn_next`  in  1  raw async button: advance to the next flag.
- `btn_prev`  in  1  raw async button: step back to the previous flag.
- `pause`  in  1  level input; freezes the auto-advance counter.
- `flag_sel`  out  SEL_W  incoming/current flag index.
- `prev_sel`  out  SEL_W  outgoing flag index. Rows with `pix_y >= wipe_y` show this flag.
- `wipe_y`  out  10  wipe row. Rows with `pix_y < wipe_y` show `flag_sel`.
- `busy`  out  1  high while a wipe is in progress.

## Operation
- Frame tick: `tick = vsync & ~vsync_q`, where `vsync_q` is `vsync` registered once. All frame-rate state updates only on cycles where `tick` is high.
- Buttons:
  - Each button passes through a 2-flop synchronizer on `clk`.
  - On each tick, the synchronized value shifts into a 2-bit sample register `s`.
  - When `s[1]==s[0]`, the debounced level takes `s[0]`.
  - A press event is a debounced 0->1 transition. A press therefore needs high samples on two consecutive ticks.
- States: HOLD and WIPE.
- HOLD, on each tick, in priority order:
  1. `btn_next` event and no `btn_prev` event: advance by +1.
  2. `btn_prev` event and no `btn_next` event: advance by -1.
  3. Both events on the same tick: cancel each other; no advance; `hold_cnt` still counts.
  4. Otherwise, if `pause` is low: `hold_cnt` increments. When `hold_cnt == HOLD_FRAMES-1` on a tick, advance by +1 instead.
  5. `pause` high: `hold_cnt` frozen. Buttons still work.
- Advance by d:
  - `prev_sel <= flag_sel`.
  - `flag_sel <= (flag_sel + d) mod NUM_FLAGS`, i.e. `NUM_FLAGS-1` wraps to 0 and 0 wraps to `NUM_FLAGS-1`.
  - `hold_cnt <= 0`; `wipe_y <= 0`; `busy <= 1`; go to WIPE.
- WIPE, on each tick:
  - If `wipe_y + WIPE_STEP >= 480` (compute in 11 bits): `wipe_y <= 480`, `prev_sel <= flag_sel`, `busy <= 0`, go to HOLD.
  - Otherwise `wipe_y <= wipe_y + WIPE_STEP`.
  - Button events are consumed and discarded. `hold_cnt` stays 0.
- In HOLD, `prev_sel == flag_sel` and `wipe_y == 480` always hold.

## Timing
- Reset values: `flag_sel=0`, `prev_sel=0`, `wipe_y=480`, `busy=0`. Internal: `hold_cnt=0`, state HOLD, `vsync_q=0`, synchronizers and sample registers 0, debounced levels 0.
- Outputs are registered. A state change caused by a tick in cycle N is visible from cycle N+1.
- A wipe spans ceil(480/WIPE_STEP) ticks from the advance tick to the return to HOLD.
- An auto-advance occurs on the `HOLD_FRAMES`-th unpaused tick spent in HOLD.
- If `reset` is asserted mid-wipe, all registers return to their reset values immediately, asynchronously.
- A `vsync` held high produces exactly one tick.

## Configuration
- `FLAG_SEQ_WIPE_EN` defined: WIPE state and wipe behaviour exactly as above.
- `FLAG_SEQ_WIPE_EN` undefined:
  - No WIPE state. Advance completes in one tick.
  - `prev_sel` updates to the new `flag_sel` on the same tick.
  - `wipe_y` is tied to 480 and `busy` is tied to 0.
  - Button events are never discarded.
  - `WIPE_STEP` is ignored.

## Test plan
- Reset, then 3 ticks with `pause=1` -> `flag_sel=0`, `prev_sel=0`, `wipe_y=480`, `busy=0` throughout.
- `HOLD_FRAMES=4`, `WIPE_STEP=160`, no buttons:
  - After 4th tick: `flag_sel=1`, `prev_sel=0`, `wipe_y=0`, `busy=1`.
  - Next ticks: `wipe_y` 160 -> 320 -> 480; on the 480 tick `prev_sel=1` and `busy=0`.
- From `flag_sel=0`, `btn_prev` high across 2 ticks -> `flag_sel=NUM_FLAGS-1`, `prev_sel=0`.
- Buttons:
  - `btn_next` high for 1 tick only -> no advance.
  - `btn_next` and `btn_prev` both pressed on the same ticks -> no advance.
  - `btn_next` held 2 ticks during a wipe -> discarded, no second advance.
- Reset asserted mid-wipe (`wipe_y=160`) -> outputs return to reset values without waiting for a clock edge.
- Build with `FLAG_SEQ_WIPE_EN` undefined, `HOLD_FRAMES=2` -> after 2nd tick `flag_sel=prev_sel=1`, `wipe_y=480`, `busy=0`.
